relu_backward: RTL and testbench
================================

RELU_BACKWARD -- requirements
Module: relu_backward

Interface
REQ-001 SHALL have parameter data_width, default 32, meaning IEEE-754 single-precision word width; only 32 is supported.
REQ-002 SHALL have parameter DEPTH, default 64, meaning mask FIFO entries; power of two, 2..1024.
REQ-003 SHALL have parameter LEAK_SHIFT, default 7, meaning negative-side slope of 2^-LEAK_SHIFT; used only when RELU_BWD_LEAKY_EN is defined.
REQ-004 SHALL provide a single clock; reset is asynchronous and active-low; ports: clk in 1 clock, rst_n in 1 async active-low reset.
REQ-005 fwd_valid  in  1  forward pre-activation word present.
REQ-006 fwd_ready  out  1  mask FIFO accepts a word.
REQ-007 data_in  in  data_width  forward pre-activation float.
REQ-008 grad_valid  in  1  upstream gradient word present.
REQ-009 grad_ready  out  1  gradient accepted this cycle.
REQ-010 grad_in  in  data_width  upstream gradient float.
REQ-011 out_valid  out  1  out_grad holds a result.
REQ-012 out_ready  in  1  downstream accepts out_grad.
REQ-013 out_grad  out  data_width  gated gradient float.
REQ-014 mask_count  out  clog2(DEPTH)+1  number of stored mask bits.

Function
REQ-015 Each fwd handshake (fwd_valid & fwd_ready) SHALL push one mask bit = ~data_in[31] & (data_in[30:0] != 0); -0.0 and +0.0 give 0, positive denormals and +NaN/+Inf give 1.
REQ-016 fwd_ready SHALL equal (mask_count != DEPTH); a push is refused when full even if a pop occurs the same cycle.
REQ-017 grad_ready SHALL equal (mask_count != 0) & (~out_valid | out_ready); there is no bypass from a same-cycle push into an empty FIFO.
REQ-018 Each grad handshake SHALL pop the oldest mask bit (FIFO order) and register the result with 1-cycle latency: out_grad = grad_in if mask = 1, else 32'h0000_0000.
REQ-019 out_valid SHALL set on a grad handshake and clear on out_valid & out_ready without a new grad handshake; out_grad SHALL hold stable while out_valid & ~out_ready.
REQ-020 Simultaneous push and pop SHALL leave mask_count unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-021 Sustained throughput SHALL be one gradient per cycle when out_ready is held high.
REQ-022 mask_count SHALL never exceed DEPTH or go below 0 under any input combination.

Reset
REQ-023 While rst_n = 0, pointers and mask_count SHALL be 0, out_valid 0, out_grad 32'h0; fwd_ready SHALL be 1 and grad_ready 0.
REQ-024 Reset asserted mid-operation SHALL discard all stored masks and any pending output immediately; no handshake completes in the cycle reset deasserts unless inputs are valid at the next rising edge.

Configuration
REQ-025 Macro RELU_BWD_LEAKY_EN: when defined, mask = 0 SHALL output grad_in scaled by 2^-LEAK_SHIFT via exponent subtraction (sign and mantissa kept); exponent <= LEAK_SHIFT SHALL flush to signed zero, and exponent 255 (Inf/NaN) SHALL pass unchanged.
REQ-026 When RELU_BWD_LEAKY_EN is undefined, mask = 0 SHALL output 32'h0000_0000 and no leak logic SHALL be synthesized.

Verification
REQ-027 Push 0xC1266666 (-10.4), 0x40B33333 (5.6), 0x00000002; then grads 0x3F800000 x3 -> out_grad 0x00000000, 0x3F800000, 0x3F800000 in order, each 1 cycle after its handshake.
REQ-028 Push DEPTH words with no grads -> fwd_ready = 0, mask_count = DEPTH; push attempted with pop same cycle -> mask_count = DEPTH-1, push not taken.
REQ-029 Empty FIFO, grad_valid = 1 and fwd push of 0x40B33333 same cycle -> grad_ready = 0 that cycle, grad accepted next cycle, out_grad = grad_in.
REQ-030 out_ready = 0 for 5 cycles with out_valid = 1 -> out_grad stable, grad_ready = 0, mask_count unchanged; out_ready = 1 -> next grad accepted same cycle.
REQ-031 rst_n pulsed low with mask_count = 10 and out_valid = 1 -> mask_count = 0, out_valid = 0, out_grad = 0 immediately, fwd_ready = 1.
REQ-032 With RELU_BWD_LEAKY_EN, LEAK_SHIFT = 7: mask 0, grad 0x3F800000 -> out_grad 0x3C000000; grad 0x03000000 -> 0x00000000.

Source files
------------

// File: rtl/relu_backward.sv
// ReLU backward pass: forward words leave a sign mask in a FIFO; each gradient pops one bit and is gated by it.
// Optional leaky slope on the negative side is enabled by defining RELU_BWD_LEAKY_EN.
module relu_backward #(
  parameter int data_width = 32,
  parameter int DEPTH      = 64,
  parameter int LEAK_SHIFT = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fwd_valid,
  output logic                      fwd_ready,
  input  logic [data_width-1:0]     data_in,
  input  logic                      grad_valid,
  output logic                      grad_ready,
  input  logic [data_width-1:0]     grad_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [data_width-1:0]     out_grad,
  output logic [$clog2(DEPTH):0]    mask_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  generate
    if (data_width != 32 || DEPTH < 2 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0 ||
        LEAK_SHIFT < 0 || LEAK_SHIFT > 254) begin : g_bad_param
      $error("relu_backward: unsupported parameter set");
    end
  endgenerate

`ifdef RELU_BWD_LEAKY_EN
  localparam logic [7:0] LEAK_SHIFT_E = 8'(LEAK_SHIFT);

  // Multiply by 2^-LEAK_SHIFT through the exponent; tiny values flush to signed zero, Inf/NaN pass.
  function automatic logic [31:0] leak_scale(input logic [31:0] g);
    logic [7:0]  e;
    logic [31:0] r;
    e = g[30:23];
    if (e == 8'hFF) begin
      r = g;
    end else if (e <= LEAK_SHIFT_E) begin
      r = {g[31], 31'd0};
    end else begin
      r = {g[31], e - LEAK_SHIFT_E, g[22:0]};
    end
    return r;
  endfunction
`endif

  logic [DEPTH-1:0]      mask_mem_r;
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  out_valid_r;
  logic [data_width-1:0] out_grad_r;

  logic                  push_s;
  logic                  pop_s;
  logic                  mask_bit_s;
  logic                  popped_mask_s;
  logic [data_width-1:0] gated_s;

  assign fwd_ready     = (count_r != FULL_COUNT);
  assign grad_ready    = (count_r != {CW{1'b0}}) & (~out_valid_r | out_ready);
  assign push_s        = fwd_valid & fwd_ready;
  assign pop_s         = grad_valid & grad_ready;
  assign mask_bit_s    = ~data_in[31] & (data_in[30:0] != 31'd0);
  assign popped_mask_s = mask_mem_r[rd_ptr_r];

  assign out_valid  = out_valid_r;
  assign out_grad   = out_grad_r;
  assign mask_count = count_r;

  // Gate the incoming gradient by the popped mask bit.
  always_comb begin
    gated_s = {data_width{1'b0}};
    if (popped_mask_s) begin
      gated_s = grad_in;
    end else begin
`ifdef RELU_BWD_LEAKY_EN
      gated_s = leak_scale(grad_in);
`else
      gated_s = {data_width{1'b0}};
`endif
    end
  end

  // Mask storage, written at the tail on each accepted forward word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_mem_r <= {DEPTH{1'b0}};
    end else if (push_s) begin
      mask_mem_r[wr_ptr_r] <= mask_bit_s;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Output register: load on a grad handshake, drop valid once consumed, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_grad_r  <= {data_width{1'b0}};
    end else if (pop_s) begin
      out_valid_r <= 1'b1;
      out_grad_r  <= gated_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_relu_backward.sv
// Self-checking bench for relu_backward: vector table plus hand sequences, with a model FIFO and output scoreboard.
module tb_relu_backward;

  localparam int DEPTH = 64;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef RELU_BWD_LEAKY_EN
  localparam bit LEAKY = 1'b1;
`else
  localparam bit LEAKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fwd_valid = 1'b0;
  logic          fwd_ready;
  logic [31:0]   data_in = 32'h0;
  logic          grad_valid = 1'b0;
  logic          grad_ready;
  logic [31:0]   grad_in = 32'h0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_grad;
  logic [CW-1:0] mask_count;

  relu_backward #(.data_width(32), .DEPTH(DEPTH), .LEAK_SHIFT(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .data_in(data_in),
    .grad_valid(grad_valid), .grad_ready(grad_ready), .grad_in(grad_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_grad(out_grad),
    .mask_count(mask_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit          mq[$];
  logic [31:0] exp_q[$];
  logic        m_ov = 1'b0;
  logic [31:0] m_og = 32'h0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] grad;
    logic [31:0] expv;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] model_out(input bit m, input logic [31:0] g);
    if (m) return g;
`ifdef RELU_BWD_LEAKY_EN
    if (g[30:23] == 8'hFF) return g;
    if (g[30:23] <= 8'd7) return {g[31], 31'd0};
    return g - 32'h0380_0000;
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] lk(input logic [31:0] leak_val);
    return LEAKY ? leak_val : 32'h0;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_ov = 1'b0;
    m_og = 32'h0;
  endtask

  task automatic check_state();
    logic [31:0] e;
    chk("fwd_ready", {31'd0, fwd_ready}, {31'd0, mq.size() != DEPTH});
    chk("grad_ready", {31'd0, grad_ready}, {31'd0, (mq.size() != 0) && (!m_ov || out_ready)});
    chk("mask_count", 32'(mask_count), mq.size());
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    if (m_ov) chk("out_grad_hold", out_grad, m_og);
    if (!rst_n) chk("rst_out_grad", out_grad, 32'h0);
    if (m_ov && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty actual=%h expected=none", out_grad);
      end else begin
        e = exp_q.pop_front();
        chk("scoreboard", out_grad, e);
      end
    end
  endtask

  task automatic model_update();
    bit fr, gr, pm;
    if (!rst_n) return;
    fr = (mq.size() != DEPTH);
    gr = (mq.size() != 0) && (!m_ov || out_ready);
    if (gr && grad_valid) begin
      pm = mq.pop_front();
      m_og = model_out(pm, grad_in);
      m_ov = 1'b1;
      exp_q.push_back(m_og);
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    if (fr && fwd_valid) mq.push_back(!data_in[31] && (data_in[30:0] != 31'd0));
  endtask

  // One clock: check at the falling edge, step the model at the rising edge, return just after it.
  task automatic tick();
    @(negedge clk);
    check_state();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drain();
    grad_valid = 1'b1;
    out_ready  = 1'b1;
    fwd_valid  = 1'b0;
    for (int k = 0; k < DEPTH + 4 && mq.size() != 0; k++) tick();
    grad_valid = 1'b0;
    tick();
    tick();
    chk("drain_empty", 32'(mask_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'hC126_6666, 32'h3F80_0000, lk(32'h3C00_0000)};
    vecs[1] = '{32'h40B3_3333, 32'h3F80_0000, 32'h3F80_0000};
    vecs[2] = '{32'h0000_0002, 32'h4049_0FDB, 32'h4049_0FDB};
    vecs[3] = '{32'h8000_0000, 32'h0300_0000, 32'h0000_0000};
    vecs[4] = '{32'h0000_0000, 32'hFF80_0000, lk(32'hFF80_0000)};
    vecs[5] = '{32'h7F80_0000, 32'hC000_0000, 32'hC000_0000};
    vecs[6] = '{32'h7FC0_0000, 32'h1234_5678, 32'h1234_5678};
    vecs[7] = '{32'hFFC0_0000, 32'hBF80_0000, lk(32'hBC00_0000)};
    vecs[8] = '{32'h8000_0001, 32'h8300_0000, lk(32'h8000_0000)};

    model_reset();
    tick();
    tick();
    chk("rst_fwd_ready", {31'd0, fwd_ready}, 32'd1);
    chk("rst_grad_ready", {31'd0, grad_ready}, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // Table: one push, one grad, compare the registered result.
    for (int i = 0; i < 9; i++) begin
      fwd_valid = 1'b1;
      data_in = vecs[i].data;
      tick();
      fwd_valid = 1'b0;
      grad_valid = 1'b1;
      grad_in = vecs[i].grad;
      tick();
      grad_valid = 1'b0;
      chk($sformatf("vec%0d", i), out_grad, vecs[i].expv);
    end
    tick();

    // Three pushes then back-to-back grads.
    begin
      logic [31:0] d3[3];
      logic [31:0] e3[3];
      d3[0] = 32'hC126_6666; d3[1] = 32'h40B3_3333; d3[2] = 32'h0000_0002;
      e3[0] = lk(32'h3C00_0000); e3[1] = 32'h3F80_0000; e3[2] = 32'h3F80_0000;
      for (int i = 0; i < 3; i++) begin
        fwd_valid = 1'b1;
        data_in = d3[i];
        tick();
      end
      fwd_valid = 1'b0;
      grad_valid = 1'b1;
      grad_in = 32'h3F80_0000;
      for (int i = 0; i < 3; i++) begin
        tick();
        chk($sformatf("seq3_out%0d", i), out_grad, e3[i]);
        chk($sformatf("seq3_valid%0d", i), {31'd0, out_valid}, 32'd1);
      end
      grad_valid = 1'b0;
      tick();
    end

    // Fill to full, then a push attempt alongside a pop.
    fwd_valid = 1'b1;
    data_in = 32'h40B3_3333;
    for (int i = 0; i < DEPTH; i++) tick();
    chk("full_fwd_ready", {31'd0, fwd_ready}, 32'd0);
    chk("full_count", 32'(mask_count), DEPTH);
    grad_valid = 1'b1;
    grad_in = 32'h3F80_0000;
    tick();
    fwd_valid = 1'b0;
    grad_valid = 1'b0;
    chk("full_pushpop_count", 32'(mask_count), DEPTH - 1);
    drain();

    // Empty FIFO: grad waits for the same-cycle push.
    fwd_valid = 1'b1;
    data_in = 32'h40B3_3333;
    grad_valid = 1'b1;
    grad_in = 32'h4049_0FDB;
    #1;
    chk("nobypass_grad_ready", {31'd0, grad_ready}, 32'd0);
    tick();
    fwd_valid = 1'b0;
    chk("nobypass_next_ready", {31'd0, grad_ready}, 32'd1);
    tick();
    grad_valid = 1'b0;
    chk("nobypass_out", out_grad, 32'h4049_0FDB);
    tick();

    // Backpressure: output held 5 cycles, then released.
    fwd_valid = 1'b1;
    data_in = 32'h3F80_0000;
    for (int i = 0; i < 3; i++) tick();
    fwd_valid = 1'b0;
    out_ready = 1'b0;
    grad_valid = 1'b1;
    grad_in = 32'h4000_0000;
    tick();
    grad_in = 32'h4040_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_out", out_grad, 32'h4000_0000);
      chk("stall_grad_ready", {31'd0, grad_ready}, 32'd0);
      chk("stall_count", 32'(mask_count), 32'd2);
    end
    out_ready = 1'b1;
    #1;
    chk("release_grad_ready", {31'd0, grad_ready}, 32'd1);
    tick();
    grad_valid = 1'b0;
    chk("release_out", out_grad, 32'h4040_0000);
    drain();

    // Reset mid-operation with 10 stored masks and a pending output.
    fwd_valid = 1'b1;
    data_in = 32'h3F80_0000;
    for (int i = 0; i < 11; i++) tick();
    fwd_valid = 1'b0;
    out_ready = 1'b0;
    grad_valid = 1'b1;
    grad_in = 32'h4080_0000;
    tick();
    grad_valid = 1'b0;
    chk("prerst_count", 32'(mask_count), 32'd10);
    chk("prerst_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_count", 32'(mask_count), 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out", out_grad, 32'h0);
    chk("midrst_fwd_ready", {31'd0, fwd_ready}, 32'd1);
    chk("midrst_grad_ready", {31'd0, grad_ready}, 32'd0);
    model_reset();
    out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
